// File: rtl/reciprocal_arb.sv
// Round-robin arbiter sharing one in-order reciprocal unit among N requesters;
// a tag FIFO steers results back. Define RECIP_ARB_STATS_EN for per-requester grant_cnt.
//
// state  | meaning
// IDLE   | search requesters round-robin from rr_ptr each cycle
// LOCKED | unit stalled the issue; grant index held until u_t_ack
module reciprocal_arb #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N-1:0]             t_req,
  output logic [N-1:0]             t_ack,
  input  logic [N*W-1:0]           t_dat,
  output logic [N-1:0]             i_req,
  input  logic [N-1:0]             i_ack,
  output logic [N*W-1:0]           i_dat,
  output logic                     u_t_req,
  input  logic                     u_t_ack,
  output logic [W-1:0]             u_t_dat,
  input  logic                     u_i_req,
  output logic                     u_i_ack,
  input  logic [W-1:0]             u_i_dat,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err
`ifdef RECIP_ARB_STATS_EN
  ,
  output logic [N*16-1:0]          grant_cnt
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   lock_g;
  logic [IW-1:0]   g;
  logic [IW-1:0]   idx;
  logic            sel_ok;
  logic [IW-1:0]   tag_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [IW-1:0]   h;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  int              k;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    g      = rr_ptr;
    sel_ok = 1'b0;
    idx    = '0;
    k      = 0;
    if (state == LOCKED) begin
      g      = lock_g;
      sel_ok = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        k = int'(rr_ptr) + i;
        if (k >= N) k = k - N;
        idx = IW'(k);
        if (!sel_ok && t_req[idx]) begin
          sel_ok = 1'b1;
          g      = idx;
        end
      end
    end
  end

  assign full    = (outstanding == OW'(DEPTH));
  assign empty   = (outstanding == '0);
  // Outputs are gated by reset so the idle values hold while reset is asserted.
  assign u_t_req = ~reset & sel_ok & ~full;
  assign u_t_dat = t_dat[g*W +: W];
  assign push    = u_t_req & u_t_ack;

  assign h       = tag_mem[rd_ptr];
  assign u_i_ack = ~reset & (empty | i_ack[h]);
  assign pop     = u_i_req & u_i_ack & ~empty;
  assign i_dat   = {N{u_i_dat}};

  always_comb begin
    t_ack = '0;
    i_req = '0;
    if (push) t_ack[g] = 1'b1;
    if (~reset & u_i_req & ~empty) i_req[h] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_g      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (u_t_req && !u_t_ack) begin
            state  <= LOCKED;
            lock_g <= g;
          end
        end
        LOCKED: begin
          if (u_t_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        rr_ptr <= (g == IW'(N - 1)) ? '0 : g + 1'b1;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (u_i_req && empty) err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= g;
  end

`ifdef RECIP_ARB_STATS_EN
  logic [15:0] cnt [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (push && cnt[g] != 16'hFFFF) begin
      cnt[g] <= cnt[g] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N; i++) grant_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule
